// File: rtl/seq_mult8.sv
// Sequential shift-and-add multiplier: one WIDTH-bit ripple-carry add per cycle, 2*WIDTH-bit product.
// Optional two's-complement operation is enabled with the SEQ_MULT8_SIGNED_EN macro.
module seq_mult8 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int P  = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // WIDTH-bit ripple-carry add; bit WIDTH of the result is the carry-out.
  function automatic logic [WIDTH:0] rca_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] res;
    logic           c;
    c = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      res[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    res[WIDTH] = c;
    return res;
  endfunction

`ifdef SEQ_MULT8_SIGNED_EN
  // Magnitude of a two's-complement operand; the most-negative value maps onto itself as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] res;
    if (x[WIDTH-1]) begin
      res = ~x + WIDTH'(1);
    end else begin
      res = x;
    end
    return res;
  endfunction
`endif

  state_t           state_r, state_s;
  logic [P-1:0]     acc_r, acc_s;
  logic [WIDTH-1:0] mcand_r, mcand_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [P-1:0]     product_r, product_s;
  logic             in_ready_r, out_valid_r, busy_r;
  logic [WIDTH:0]   sum_s;
  logic [P-1:0]     step_acc_s;
  logic [P-1:0]     final_s;
  logic [WIDTH-1:0] load_mcand_s;
  logic [WIDTH-1:0] load_mplier_s;
`ifdef SEQ_MULT8_SIGNED_EN
  logic             neg_r, neg_s;
`endif

  // One shift-and-add iteration; the carry-out lands in the accumulator MSB.
  always_comb begin
    sum_s = {(WIDTH+1){1'b0}};
    if (acc_r[0]) begin
      sum_s = rca_add(acc_r[P-1:WIDTH], mcand_r);
    end else begin
      sum_s = {1'b0, acc_r[P-1:WIDTH]};
    end
    step_acc_s = {sum_s, acc_r[WIDTH-1:1]};
  end

  // Operand conditioning at acceptance and result fix-up on the way into DONE.
  always_comb begin
    load_mcand_s  = a;
    load_mplier_s = b;
    final_s       = step_acc_s;
`ifdef SEQ_MULT8_SIGNED_EN
    load_mcand_s  = mag(a);
    load_mplier_s = mag(b);
    if (neg_r) begin
      final_s = ~step_acc_s + P'(1);
    end else begin
      final_s = step_acc_s;
    end
`endif
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_s   = state_r;
    acc_s     = acc_r;
    mcand_s   = mcand_r;
    cnt_s     = cnt_r;
    product_s = product_r;
`ifdef SEQ_MULT8_SIGNED_EN
    neg_s     = neg_r;
`endif
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          mcand_s = load_mcand_s;
          acc_s   = {{WIDTH{1'b0}}, load_mplier_s};
          cnt_s   = {CW{1'b0}};
`ifdef SEQ_MULT8_SIGNED_EN
          neg_s   = a[WIDTH-1] ^ b[WIDTH-1];
`endif
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        acc_s = step_acc_s;
        cnt_s = cnt_r + CW'(1);
        if (cnt_r == LAST) begin
          product_s = final_s;
          state_s   = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= {P{1'b0}};
      mcand_r     <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      product_r   <= {P{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      mcand_r     <= mcand_s;
      cnt_r       <= cnt_s;
      product_r   <= product_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
    end
  end

`ifdef SEQ_MULT8_SIGNED_EN
  // Result sign captured at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_r <= 1'b0;
    end else begin
      neg_r <= neg_s;
    end
  end
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign product   = product_r;

endmodule

// File: doc/seq_mult8.md
Name: seq_mult8

Overview:
- Sequential shift-and-add multiplier. Consumes the team's 8-bit ripple-carry adder datapath: one WIDTH-bit add with carry-out per cycle.
- Produces a 2*WIDTH-bit product after WIDTH iterations.
- Sits downstream of operand sources and feeds the result consumer through a valid/ready handshake on each side.

Parameters:
- WIDTH, 8: operand width in bits. Product width is 2*WIDTH. Legal values are 2 to 16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair a/b is valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer accepts the product.
- product  output  2*WIDTH  result a*b.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Single clock. Reset is asynchronous and active-low (rst_n); all state registers clear immediately when rst_n falls.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - product = 0. Internal accumulator, multiplicand register and iteration counter = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: latch a into the multiplicand register, load the accumulator with {WIDTH'b0, b}, clear the counter, go to RUN.
  - With in_valid = 0: stay in IDLE.
- RUN:
  - in_ready = 0.
  - Each cycle: if acc[0] = 1, compute {carry, upper} = acc[2W-1:W] + multiplicand with a WIDTH-bit add and carry-out; otherwise carry = 0 and upper = acc[2W-1:W].
  - Then acc <= {carry, upper, acc[W-1:1]} (shift right by one, carry into the MSB).
  - The counter increments each cycle. After the WIDTH-th iteration, go to DONE.
  - The carry is never lost. No overflow is possible because the product always fits in 2*WIDTH bits.
- DONE:
  - out_valid = 1 and product = acc.
  - product and out_valid hold stable until out_ready = 1.
  - On an edge with out_ready = 1: out_valid -> 0, go to IDLE.
  - in_ready stays 0 in DONE. There is no overlap between an output transfer and a new input acceptance in the same cycle; the next operand can be accepted one cycle after the output transfer.
- Latency:
  - Acceptance edge t0 -> out_valid high after edge t0 + WIDTH (8 cycles for the default).
  - Throughput is at most one product per WIDTH + 2 cycles.
- product register:
  - Updated only when entering DONE.
  - Keeps its last value in IDLE and RUN. It is not meaningful unless out_valid = 1.
- Ignored inputs:
  - in_valid is ignored outside IDLE. a/b changing during RUN has no effect.
  - out_ready is ignored outside DONE.
- Zero operands: take the full WIDTH iterations and yield 0. There is no early termination.
- Reset mid-operation: an in-progress or pending result is discarded, and all outputs return to reset values asynchronously.
- busy = (state != IDLE).

Optional Feature:
- Macro: SEQ_MULT8_SIGNED_EN.
- Defined:
  - a and b are two's-complement. product is the signed 2*WIDTH-bit two's-complement product.
  - Implementation: latch operand magnitudes and the result sign (a[W-1] ^ b[W-1]) in IDLE, run the unsigned iteration, then conditionally negate the accumulator on the transition to DONE.
  - Latency is unchanged. The most-negative operand (0x80 for WIDTH = 8) must be handled: its magnitude 0x80 is representable as unsigned.
- Undefined: operands are unsigned and no sign logic is synthesized.

Test Plan:
- Reset then idle: hold rst_n = 0 for 3 cycles, release -> in_ready = 1, out_valid = 0, busy = 0, product = 0x0000.
- Basic unsigned: a = 0x0D, b = 0x0B, in_valid pulsed for one cycle, out_ready = 1 -> out_valid high exactly 8 cycles after the acceptance edge, product = 0x008F, back to IDLE one cycle later.
- Max carry path: a = 0xFF, b = 0xFF -> product = 0xFE01. Then a = 0x00, b = 0xA5 -> product = 0x0000, also after 8 cycles.
- Output backpressure: a = 0x10, b = 0x10, out_ready held 0 for 5 cycles after out_valid -> product stays 0x0100 and out_valid stays 1. A new in_valid with a = 0x02, b = 0x03 during this time is not accepted (in_ready = 0). Raising out_ready -> transfer, then the new pair is accepted and yields 0x0006.
- Reset mid-operation: accept a = 0x33, b = 0x44, assert rst_n = 0 at iteration 4 -> immediate IDLE and out_valid = 0. The next operation, a = 0x03, b = 0x05, yields 0x000F.
- Signed (SEQ_MULT8_SIGNED_EN defined):
  - 0xFF * 0x02 -> 0xFFFE.
  - 0x80 * 0x80 -> 0x4000.
  - 0x80 * 0x7F -> 0xC080.
  - With the macro undefined, 0xFF * 0x02 -> 0x01FE.
